// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller.
//
// A single full_add cell is reused for every bit of a WIDTH-bit addition.
// On an accepted start the operands and carry-in are latched. One bit pair
// is then fed per cycle, LSB first, and each sum bit is shifted into the
// result register from the MSB side.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   begin an addition (accepted in IDLE or DONE only)
//   op_a   in   [WIDTH-1:0] operand A
//   op_b   in   [WIDTH-1:0] operand B
//   cin    in   carry-in
//   sub    in   subtract select (only when SERIAL_ADD_SUB_EN is defined)
//   busy   out  high while the addition runs
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  [WIDTH-1:0] result, held until the next accepted start
//   cout   out  final carry-out (for subtraction: 1 = no borrow)
//
// Build option: define SERIAL_ADD_SUB_EN to add the sub port and subtraction.

module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    full_add u_fa (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c     (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // Subtraction is A + ~B + 1; the carry-in is forced to 1 and cin ignored.
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load = sub ? ~op_b : op_b;
    assign w_c_load = sub ? 1'b1  : cin;
`else
    assign w_b_load = op_b;
    assign w_c_load = cin;
`endif

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= op_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
        end else if (r_state == S_RUN) begin
            r_carry <= w_fa_carry;
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_fa_carry;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl -- directed bench for serial_add_ctrl (WIDTH=8).
// Vector table for plain additions, then hand-written sequences for
// start-during-RUN, reset mid-RUN and back-to-back starts. Subtraction
// vectors are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total;
    int bad;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Called at the first negedge after the start edge. Counts cycles until
    // done is seen (bounded); optionally pulses start mid-RUN at cycle inj.
    task automatic wait_done(input int inj, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) bcnt++;
            if (cyc == inj) begin
                start = 1'b1;
                op_a  = 8'hAA;
                op_b  = 8'h55;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic begin_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t vecs[$];
    int   cyc;
    int   bcnt;
    int   seen_done;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        sub   = 1'b0;

        vecs.push_back('{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
`endif

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum",  {24'd0, sum},  32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            begin_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
            wait_done(-1, cyc, bcnt);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, W);
            chk($sformatf("v%0d_latency", i), cyc, W);
            chk($sformatf("v%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
            chk($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_hold_sum", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
            chk($sformatf("v%0d_hold_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
        end
        sub = 1'b0;

        // start during RUN must be ignored
        begin_op(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(2, cyc, bcnt);
        chk("ign_latency", cyc, W);
        chk("ign_sum",  {24'd0, sum},  32'h30);
        chk("ign_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        chk("ign_idle", {30'd0, busy, done}, 32'd0);

        // reset in the middle of RUN
        begin_op(8'h3C, 8'h5A, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_sum",  {24'd0, sum},  32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("mid_rst_quiet", seen_done, 0);

        // back-to-back: start held during the done cycle
        begin_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(-1, cyc, bcnt);
        chk("b2b_first_sum",  {24'd0, sum},  32'h00);
        chk("b2b_first_cout", {31'd0, cout}, 32'd1);
        begin_op(8'h01, 8'h01, 1'b0, 1'b0);
        chk("b2b_busy_next", {31'd0, busy}, 32'd1);
        wait_done(-1, cyc, bcnt);
        // done edge is one cycle after the first done edge plus cyc more
        chk("b2b_done_gap", cyc + 1, W + 1);
        chk("b2b_sum",  {24'd0, sum},  32'h02);
        chk("b2b_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
